single_cycle_cpu: RTL and testbench

//  Single-cycle 32-bit MIPS-subset processor core. It retires one instruction per clk.

---
 rtl/single_cycle_cpu.sv | 227 ++++++++++++++++++++++
 tb/tb_single_cycle_cpu.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/single_cycle_cpu.sv
// Single-cycle 32-bit MIPS-subset core with private instruction and data word RAMs (Harvard).
// Optional build macro HALT_ON_SYSCALL_EN: a syscall with $2 == 10 freezes the core until reset.

module scc_word_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];
endmodule

module single_cycle_cpu #(
    parameter int MEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] regs_debug [0:31],
    output logic [31:0] pc_debug,
    output logic [31:0] instr_debug
);
    localparam int AW = $clog2(MEM_DEPTH);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE   = 6'h05, OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D, OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F, OP_LW    = 6'h23, OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03, F_JR   = 6'h08;
    localparam logic [5:0] F_SYSC = 6'h0C, F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23, F_AND  = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27, F_SLT  = 6'h2A, F_SLTU = 6'h2B;

    logic [31:0] pc_q, pc_d;
    logic [31:0] regs_q [0:31];
    logic [31:0] regs_d [0:31];
    logic        halted_q, halted_d;

    logic [31:0] instr;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] rs_val, rt_val, imm_sext, imm_zext;
    logic [31:0] pc_plus4, branch_target, jump_target, mem_addr, dmem_rdata;
    logic        unused_addr_bits;

    logic        wb_en, is_sw, is_syscall, halt_req, commit, dmem_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data, pc_next;

    scc_word_ram #(.DEPTH(MEM_DEPTH)) instr_ram (
        .clk   (clk),
        .we    (1'b0),
        .addr  (pc_q[AW+1:2]),
        .wdata (32'h0),
        .rdata (instr)
    );

    scc_word_ram #(.DEPTH(MEM_DEPTH)) data_ram (
        .clk   (clk),
        .we    (dmem_we),
        .addr  (mem_addr[AW+1:2]),
        .wdata (rt_val),
        .rdata (dmem_rdata)
    );

    assign opcode   = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign imm      = instr[15:0];
    assign target   = instr[25:0];

    assign rs_val   = regs_q[rs];
    assign rt_val   = regs_q[rt];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'h0, imm};

    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], target, 2'b00};
    assign mem_addr      = rs_val + imm_sext;
    // Byte offset and high address bits are intentionally dropped: word-granular, wrapping memory.
    assign unused_addr_bits = ^{mem_addr[31:AW+2], mem_addr[1:0]};

    always_comb begin
        wb_en      = 1'b0;
        wb_addr    = rt;
        wb_data    = 32'h0;
        is_sw      = 1'b0;
        is_syscall = 1'b0;
        pc_next    = pc_plus4;
        case (opcode)
            OP_RTYPE: begin
                wb_addr = rd;
                wb_en   = 1'b1;
                case (funct)
                    F_ADD, F_ADDU: wb_data = rs_val + rt_val;
                    F_SUB, F_SUBU: wb_data = rs_val - rt_val;
                    F_AND:  wb_data = rs_val & rt_val;
                    F_OR:   wb_data = rs_val | rt_val;
                    F_XOR:  wb_data = rs_val ^ rt_val;
                    F_NOR:  wb_data = ~(rs_val | rt_val);
                    F_SLT:  wb_data = {31'h0, $signed(rs_val) < $signed(rt_val)};
                    F_SLTU: wb_data = {31'h0, rs_val < rt_val};
                    F_SLL:  wb_data = rt_val << shamt;
                    F_SRL:  wb_data = rt_val >> shamt;
                    F_SRA:  wb_data = $signed(rt_val) >>> shamt;
                    F_JR: begin
                        wb_en   = 1'b0;
                        pc_next = rs_val;
                    end
                    F_SYSC: begin
                        wb_en      = 1'b0;
                        is_syscall = 1'b1;
                    end
                    default: wb_en = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                wb_en   = 1'b1;
                wb_data = rs_val + imm_sext;
            end
            OP_SLTI: begin
                wb_en   = 1'b1;
                wb_data = {31'h0, $signed(rs_val) < $signed(imm_sext)};
            end
            OP_SLTIU: begin
                wb_en   = 1'b1;
                wb_data = {31'h0, rs_val < imm_sext};
            end
            OP_ANDI: begin
                wb_en   = 1'b1;
                wb_data = rs_val & imm_zext;
            end
            OP_ORI: begin
                wb_en   = 1'b1;
                wb_data = rs_val | imm_zext;
            end
            OP_XORI: begin
                wb_en   = 1'b1;
                wb_data = rs_val ^ imm_zext;
            end
            OP_LUI: begin
                wb_en   = 1'b1;
                wb_data = {imm, 16'h0};
            end
            OP_LW: begin
                wb_en   = 1'b1;
                wb_data = dmem_rdata;
            end
            OP_SW:  is_sw = 1'b1;
            OP_BEQ: if (rs_val == rt_val) pc_next = branch_target;
            OP_BNE: if (rs_val != rt_val) pc_next = branch_target;
            OP_J:   pc_next = jump_target;
            OP_JAL: begin
                wb_en   = 1'b1;
                wb_addr = 5'd31;
                wb_data = pc_plus4;
                pc_next = jump_target;
            end
            default: ;
        endcase
    end

`ifdef HALT_ON_SYSCALL_EN
    assign halt_req = is_syscall && (regs_q[2] == 32'd10);
`else
    assign halt_req = 1'b0;
`endif

    // The halting syscall itself commits nothing, so PC stays on it.
    assign commit  = !halted_q && !halt_req;
    assign dmem_we = commit && is_sw && !reset;

    always_comb begin
        halted_d = halted_q | halt_req;
        pc_d     = commit ? pc_next : pc_q;
        for (int i = 0; i < 32; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (commit && wb_en && (wb_addr != 5'd0)) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= 32'h0;
            halted_q <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_regs_debug
            assign regs_debug[gi] = regs_q[gi];
        end
    endgenerate

    assign pc_debug    = pc_q;
    assign instr_debug = instr;
endmodule

// File: tb/tb_single_cycle_cpu.sv
// Directed-program testbench for single_cycle_cpu; programs are poked into dut.instr_ram.mem.
// Expected register/PC values are hand-derived from each program listing.

module tb_single_cycle_cpu;
    localparam int DEPTH = 1024;

    localparam logic [5:0] OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F;
    localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_JR = 6'h08;
    localparam logic [5:0] F_SYSC = 6'h0C, F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A, F_SLTU = 6'h2B;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] regs_debug [0:31];
    logic [31:0] pc_debug;
    logic [31:0] instr_debug;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    single_cycle_cpu #(.MEM_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .regs_debug  (regs_debug),
        .pc_debug    (pc_debug),
        .instr_debug (instr_debug)
    );

    function automatic logic [31:0] enc_r(input logic [5:0] funct, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
        return {op, t};
    endfunction

    task automatic clear_imem;
        for (int i = 0; i < DEPTH; i++) dut.instr_ram.mem[i] = 32'h0;
    endtask

    // Holds reset for two edges; returns on the negedge just after reset drops (PC == 0).
    task automatic start_program;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1;
        clear_imem();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        $display("reset: pc=%h instr=%h", pc_debug, instr_debug);
        if (pc_debug !== 32'h0) $display("FAIL reset_pc got %h want %h", pc_debug, 32'h0);
        else pass_cnt++;
        total_cnt++;
        for (int r = 0; r < 32; r++) begin
            if (regs_debug[r] !== 32'h0) $display("FAIL reset_reg%0d got %h want 0", r, regs_debug[r]);
            else pass_cnt++;
            total_cnt++;
        end
        reset = 1'b0;
        run(1);
        $display("release: pc=%h", pc_debug);
        if (pc_debug !== 32'h4) $display("FAIL release_pc got %h want %h", pc_debug, 32'h4);
        else pass_cnt++;
        total_cnt++;
    endtask

    task automatic test_lw_sw;
        int          rn  [7] = '{8, 9, 16, 2, 4, 12, 13};
        logic [31:0] exp [7] = '{32'h1234, 32'h1234, 32'h0, 32'hA, 32'h100, 32'hFFFFFFFE, 32'hFFFFFFFE};
        @(negedge clk);
        reset = 1'b1;
        clear_imem();
        dut.instr_ram.mem[0] = enc_i(OP_ADDIU, 5'd0, 5'd8, 16'h1234);
        dut.instr_ram.mem[1] = enc_i(OP_ADDIU, 5'd0, 5'd4, 16'h0100);
        dut.instr_ram.mem[2] = enc_i(OP_SW, 5'd4, 5'd8, 16'h0000);
        dut.instr_ram.mem[3] = enc_i(OP_LW, 5'd4, 5'd9, 16'h0000);
        dut.instr_ram.mem[4] = enc_r(F_SUB, 5'd8, 5'd9, 5'd16, 5'd0);
        dut.instr_ram.mem[5] = enc_i(OP_ADDIU, 5'd0, 5'd2, 16'h000A);
        dut.instr_ram.mem[6] = enc_i(OP_ADDIU, 5'd0, 5'd11, 16'hFFFE);
        dut.instr_ram.mem[7] = enc_i(OP_SW, 5'd4, 5'd11, 16'h0008);
        dut.instr_ram.mem[8] = enc_i(OP_LW, 5'd4, 5'd12, 16'h0008);
        dut.instr_ram.mem[9] = enc_i(OP_LW, 5'd4, 5'd13, 16'h0009);
        start_program();
        run(25);
        for (int i = 0; i < 7; i++) begin
            $display("lw_sw: $%0d=%h expect %h", rn[i], regs_debug[rn[i]], exp[i]);
            if (regs_debug[rn[i]] !== exp[i])
                $display("FAIL lw_sw_reg%0d got %h want %h", rn[i], regs_debug[rn[i]], exp[i]);
            else pass_cnt++;
            total_cnt++;
        end
    endtask

    task automatic test_alu;
        int          rn  [21] = '{8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 0};
        logic [31:0] exp [21] = '{32'hFFFFFFFE, 32'h1, 32'h0, 32'h1, 32'h0, 32'hABCD0000, 32'h2,
                                  32'hABCD0000, 32'hABCD0001, 32'h5432FFFF, 32'hFFFFFFFE, 32'h10,
                                  32'hF, 32'hFABCD000, 32'h0000F0F0, 32'hABCD1234, 32'hFFFF0000,
                                  32'h1, 32'h1, 32'h579A0000, 32'h0};
        @(negedge clk);
        reset = 1'b1;
        clear_imem();
        dut.instr_ram.mem[0]  = enc_i(OP_ADDI, 5'd0, 5'd8, 16'hFFFF);
        dut.instr_ram.mem[1]  = enc_i(OP_ADDIU, 5'd0, 5'd9, 16'h0001);
        dut.instr_ram.mem[2]  = enc_r(F_ADDU, 5'd8, 5'd9, 5'd10, 5'd0);
        dut.instr_ram.mem[3]  = enc_r(F_SLT, 5'd8, 5'd9, 5'd11, 5'd0);
        dut.instr_ram.mem[4]  = enc_r(F_SLTU, 5'd8, 5'd9, 5'd12, 5'd0);
        dut.instr_ram.mem[5]  = enc_i(OP_LUI, 5'd0, 5'd13, 16'hABCD);
        dut.instr_ram.mem[6]  = enc_r(F_SUB, 5'd9, 5'd8, 5'd14, 5'd0);
        dut.instr_ram.mem[7]  = enc_r(F_AND, 5'd13, 5'd8, 5'd15, 5'd0);
        dut.instr_ram.mem[8]  = enc_r(F_OR, 5'd9, 5'd13, 5'd16, 5'd0);
        dut.instr_ram.mem[9]  = enc_r(F_XOR, 5'd8, 5'd13, 5'd17, 5'd0);
        dut.instr_ram.mem[10] = enc_r(F_NOR, 5'd0, 5'd9, 5'd18, 5'd0);
        dut.instr_ram.mem[11] = enc_r(F_SLL, 5'd0, 5'd9, 5'd19, 5'd4);
        dut.instr_ram.mem[12] = enc_r(F_SRL, 5'd0, 5'd8, 5'd20, 5'd28);
        dut.instr_ram.mem[13] = enc_r(F_SRA, 5'd0, 5'd13, 5'd21, 5'd4);
        dut.instr_ram.mem[14] = enc_i(OP_ANDI, 5'd8, 5'd22, 16'hF0F0);
        dut.instr_ram.mem[15] = enc_i(OP_ORI, 5'd13, 5'd23, 16'h1234);
        dut.instr_ram.mem[16] = enc_i(OP_XORI, 5'd8, 5'd24, 16'hFFFF);
        dut.instr_ram.mem[17] = enc_i(OP_SLTI, 5'd8, 5'd25, 16'h0000);
        dut.instr_ram.mem[18] = enc_i(OP_SLTIU, 5'd9, 5'd26, 16'hFFFF);
        dut.instr_ram.mem[19] = enc_r(F_ADD, 5'd8, 5'd8, 5'd8, 5'd0);
        dut.instr_ram.mem[20] = enc_r(F_ADD, 5'd13, 5'd13, 5'd27, 5'd0);
        start_program();
        run(23);
        for (int i = 0; i < 21; i++) begin
            $display("alu: $%0d=%h expect %h", rn[i], regs_debug[rn[i]], exp[i]);
            if (regs_debug[rn[i]] !== exp[i])
                $display("FAIL alu_reg%0d got %h want %h", rn[i], regs_debug[rn[i]], exp[i]);
            else pass_cnt++;
            total_cnt++;
        end
    endtask

    task automatic test_control;
        logic [31:0] pc_exp [11] = '{32'h04, 32'h10, 32'h14, 32'h18, 32'h40, 32'h60,
                                     32'h64, 32'h44, 32'h48, 32'h48, 32'h48};
        int          rn  [8] = '{8, 9, 10, 11, 12, 13, 14, 31};
        logic [31:0] exp [8] = '{32'h1, 32'h0, 32'h0, 32'h3, 32'h0, 32'h5, 32'h6, 32'h44};
        @(negedge clk);
        reset = 1'b1;
        clear_imem();
        dut.instr_ram.mem[0]  = enc_i(OP_ADDIU, 5'd0, 5'd8, 16'h0001);
        dut.instr_ram.mem[1]  = enc_i(OP_BEQ, 5'd0, 5'd0, 16'h0002);
        dut.instr_ram.mem[2]  = enc_i(OP_ADDIU, 5'd0, 5'd9, 16'h0007);
        dut.instr_ram.mem[3]  = enc_i(OP_ADDIU, 5'd0, 5'd10, 16'h0007);
        dut.instr_ram.mem[4]  = enc_i(OP_BNE, 5'd0, 5'd0, 16'h0005);
        dut.instr_ram.mem[5]  = enc_i(OP_ADDIU, 5'd0, 5'd11, 16'h0003);
        dut.instr_ram.mem[6]  = enc_j(OP_J, 26'h10);
        dut.instr_ram.mem[7]  = enc_i(OP_ADDIU, 5'd0, 5'd12, 16'h0009);
        dut.instr_ram.mem[16] = enc_j(OP_JAL, 26'h18);
        dut.instr_ram.mem[17] = enc_i(OP_ADDIU, 5'd0, 5'd13, 16'h0005);
        dut.instr_ram.mem[18] = enc_i(OP_BEQ, 5'd13, 5'd13, 16'hFFFF);
        dut.instr_ram.mem[24] = enc_i(OP_ADDIU, 5'd0, 5'd14, 16'h0006);
        dut.instr_ram.mem[25] = enc_r(F_JR, 5'd31, 5'd0, 5'd0, 5'd0);
        start_program();
        for (int c = 0; c < 11; c++) begin
            run(1);
            $display("control: cycle %0d pc=%h expect %h", c + 1, pc_debug, pc_exp[c]);
            if (pc_debug !== pc_exp[c])
                $display("FAIL control_pc_cycle%0d got %h want %h", c + 1, pc_debug, pc_exp[c]);
            else pass_cnt++;
            total_cnt++;
        end
        for (int i = 0; i < 8; i++) begin
            $display("control: $%0d=%h expect %h", rn[i], regs_debug[rn[i]], exp[i]);
            if (regs_debug[rn[i]] !== exp[i])
                $display("FAIL control_reg%0d got %h want %h", rn[i], regs_debug[rn[i]], exp[i]);
            else pass_cnt++;
            total_cnt++;
        end
    endtask

    task automatic test_zero_wrap;
        logic [31:0] first_word;
        int          rn  [4] = '{0, 5, 4, 10};
        logic [31:0] exp [4] = '{32'h0, 32'h0, 32'h1000, 32'h5A5A};
        first_word = enc_i(OP_ADDI, 5'd0, 5'd0, 16'h0005);
        @(negedge clk);
        reset = 1'b1;
        clear_imem();
        dut.instr_ram.mem[0] = first_word;
        dut.instr_ram.mem[1] = enc_r(F_ADDU, 5'd0, 5'd0, 5'd5, 5'd0);
        dut.instr_ram.mem[2] = enc_i(OP_ADDIU, 5'd0, 5'd9, 16'h5A5A);
        dut.instr_ram.mem[3] = enc_i(OP_ADDIU, 5'd0, 5'd4, 16'h1000);
        dut.instr_ram.mem[4] = enc_i(OP_SW, 5'd4, 5'd9, 16'h0000);
        dut.instr_ram.mem[5] = enc_i(OP_LW, 5'd0, 5'd10, 16'h0000);
        dut.instr_ram.mem[6] = enc_j(OP_J, 26'h400);
        start_program();
        run(7);
        $display("wrap: pc=%h instr=%h", pc_debug, instr_debug);
        if (pc_debug !== 32'h1000) $display("FAIL wrap_pc got %h want %h", pc_debug, 32'h1000);
        else pass_cnt++;
        total_cnt++;
        if (instr_debug !== first_word) $display("FAIL wrap_fetch got %h want %h", instr_debug, first_word);
        else pass_cnt++;
        total_cnt++;
        for (int i = 0; i < 4; i++) begin
            $display("zero_wrap: $%0d=%h expect %h", rn[i], regs_debug[rn[i]], exp[i]);
            if (regs_debug[rn[i]] !== exp[i])
                $display("FAIL zero_wrap_reg%0d got %h want %h", rn[i], regs_debug[rn[i]], exp[i]);
            else pass_cnt++;
            total_cnt++;
        end
        run(1);
        if (pc_debug !== 32'h1004) $display("FAIL wrap_pc_next got %h want %h", pc_debug, 32'h1004);
        else pass_cnt++;
        total_cnt++;
    endtask

    task automatic test_syscall;
        logic [31:0] pc_exp;
        logic [31:0] r3_exp;
        @(negedge clk);
        reset = 1'b1;
        clear_imem();
        dut.instr_ram.mem[0] = enc_i(OP_ADDIU, 5'd0, 5'd2, 16'h0003);
        dut.instr_ram.mem[1] = enc_r(F_SYSC, 5'd0, 5'd0, 5'd0, 5'd0);
        dut.instr_ram.mem[2] = enc_i(OP_ADDIU, 5'd0, 5'd2, 16'h000A);
        dut.instr_ram.mem[3] = enc_r(F_SYSC, 5'd0, 5'd0, 5'd0, 5'd0);
        dut.instr_ram.mem[4] = enc_i(OP_ADDIU, 5'd0, 5'd3, 16'h0001);
        start_program();
        run(3);
        if (pc_debug !== 32'hC) $display("FAIL syscall_nop_pc got %h want %h", pc_debug, 32'hC);
        else pass_cnt++;
        total_cnt++;
        pc_exp = 32'hC;
        for (int c = 0; c < 10; c++) begin
            run(1);
`ifdef HALT_ON_SYSCALL_EN
            pc_exp = 32'hC;
`else
            pc_exp = pc_exp + 32'd4;
`endif
            $display("syscall: cycle %0d pc=%h expect %h", c + 1, pc_debug, pc_exp);
            if (pc_debug !== pc_exp)
                $display("FAIL syscall_pc_cycle%0d got %h want %h", c + 1, pc_debug, pc_exp);
            else pass_cnt++;
            total_cnt++;
        end
`ifdef HALT_ON_SYSCALL_EN
        r3_exp = 32'h0;
`else
        r3_exp = 32'h1;
`endif
        if (regs_debug[3] !== r3_exp) $display("FAIL syscall_reg3 got %h want %h", regs_debug[3], r3_exp);
        else pass_cnt++;
        total_cnt++;
    endtask

    initial begin
        test_reset();
        test_lw_sw();
        test_alu();
        test_control();
        test_zero_wrap();
        test_syscall();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
